pipe_select_mux: RTL and testbench
==================================

# pipe_select_mux

Parametrised, pipelined N-way selector for the MIPS pipeline datapath, the registered successor to the 2:1 5-bit combinational mux. It selects one of NUM_IN WIDTH-bit inputs, such as a register destination (rt/rd/$31) or forwarding source, and carries the result through STAGES registered stages. Each stage has a valid bit, so the selection stays aligned with instructions as they move through EX/MEM/WB under stall and flush.

## Interface
- WIDTH, 5, data width in bits (≥1)
- NUM_IN, 4, number of selectable inputs (2..16)
- SEL_W, 2, select width; must satisfy 2^SEL_W ≥ NUM_IN
- STAGES, 3, pipeline depth and latency in cycles (1..8)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_bus  in  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  input index, sampled with in_valid
- in_valid  in  1  the current sel/in_bus pair is an instruction slot to capture
- stall  in  1  hold every stage; do not capture
- flush  in  1  kill every slot in flight, including this cycle's input
- out_data  out  WIDTH  data from the final stage
- out_valid  out  1  out_data belongs to a valid slot
- sel_err  out  1  the final-stage slot had an out-of-range or unknown select
- busy  out  1  at least one stage holds a valid slot (OR of stage valids)

## Operation
- Stage 0 captures mux(in_bus, sel), in_valid and the select-error bit. Stage i captures stage i-1. Final stage = outputs.
- Invalid slots carry zero data and sel_err=0. A bubble entering stage 0 (in_valid=0) loads data 0.
- Priority per edge: rst > flush > stall > advance.
- flush=1: every stage valid, data and err bit cleared to 0 on the next edge. The input that cycle is discarded.
- stall=1 (flush=0): every stage, including stage 0, holds. The input is not captured; the producer holds it until stall drops.
- Advance: all stages shift one position on the edge.
- Reset mid-operation: all stages clear immediately (asynchronous). The first capture happens on the first rising edge after rst deasserts.
- Arithmetic: none. Selection is index-only. No width extension; every data path is WIDTH bits.

## Timing
- Latency is exactly STAGES rising edges from capture to out_data/out_valid when there is no stall. Throughput is one slot per cycle.
- out_data, out_valid, sel_err and busy are registered, apart from the OR in busy. No combinational path from any input to any output.
- Reset values: out_data=0, out_valid=0, sel_err=0, busy=0.
- If stall is held for S cycles, the latency of in-flight slots grows by S.
- busy drops on the edge at which the last valid slot leaves the final stage, or on flush.

## Configuration
- PIPE_MUX_RANGE_CHECK_EN defined:
  - A slot with sel ≥ NUM_IN, or with sel containing X/Z (checked with ===), stores data 0 and err=1.
  - The err bit travels with the slot and appears on sel_err.
- PIPE_MUX_RANGE_CHECK_EN undefined:
  - An out-of-range sel selects input 0. An X sel gives simulator-defined data.
  - sel_err is tied to 0.
  - No range-check logic is synthesised.

## Test plan
Defaults: WIDTH=5, NUM_IN=4, STAGES=3; in0=01010, in1=10101, in2=00000, in3=11111.
- Reset and latency: hold rst 2 cycles, then sel=1 with in_valid=1 for one cycle -> out_valid=0 for two edges; on the 3rd edge out_data=10101 and out_valid=1; busy=1 from the first edge.
- Streaming: sel=0,1,2,3 on consecutive cycles -> outputs 01010, 10101, 00000, 11111 on consecutive cycles starting at edge 3, with out_valid held high.
- Stall: issue sel=3, then stall for 2 cycles -> 11111 appears at edge 5 instead of edge 3; outputs stay constant during the stall.
- Flush: issue sel=1, sel=2, then flush with stall=1 simultaneously -> flush wins; out_valid=0, out_data=00000 and busy=0 after the next edge; no 10101 or 00000 ever appears as a valid output.
- Range check (macro defined, SEL_W=3): sel=3'b101 and then sel=3'bx0x -> two valid slots with out_data=0 and sel_err=1. With the macro undefined, sel=3'b101 -> out_data=01010 and sel_err=0.
- Async reset mid-stream: while streaming, assert rst between edges -> all outputs read 0 before the next edge; the stream resumes cleanly with 3-cycle latency after rst drops.

Source files
------------

// File: rtl/pipe_select_mux.sv
// Pipelined NUM_IN-way selector with per-stage valid, stall and flush.
// Optional range checking of the select is enabled by PIPE_MUX_RANGE_CHECK_EN.
module pipe_select_mux #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int STAGES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    sel_err,
  output logic                    busy
);

  // Index-only selection; any select that matches no input falls back to input 0.
  function automatic logic [WIDTH-1:0] pick(input logic [NUM_IN*WIDTH-1:0] bus,
                                            input logic [SEL_W-1:0]        s);
    logic [WIDTH-1:0] r;
    r = bus[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++) begin
      if (s == SEL_W'(k)) r = bus[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  logic [WIDTH-1:0]  cap_data;
  logic              cap_vld;
  logic [WIDTH-1:0]  data_p [STAGES];
  logic [STAGES-1:0] vld_p;

  assign cap_vld = in_valid;

`ifdef PIPE_MUX_RANGE_CHECK_EN
  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);

  function automatic logic bad_sel(input logic [SEL_W-1:0] s);
    logic bad;
    bad = ({1'b0, s} >= NUM_IN_L);
    if ((^s) === 1'bx) bad = 1'b1;
    return bad;
  endfunction

  logic              cap_err;
  logic [STAGES-1:0] err_p;

  always_comb begin
    cap_err  = in_valid & bad_sel(sel);
    cap_data = (in_valid && !cap_err) ? pick(in_bus, sel) : '0;
  end

  // Error bits ride alongside the valid bits with identical control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_p <= '0;
    end else if (flush) begin
      err_p <= '0;
    end else if (!stall) begin
      err_p[0] <= cap_err;
      for (int i = 1; i < STAGES; i++) err_p[i] <= err_p[i-1];
    end
  end

  assign sel_err = err_p[STAGES-1];
`else
  always_comb begin
    cap_data = in_valid ? pick(in_bus, sel) : '0;
  end

  assign sel_err = 1'b0;
`endif

  // Stage 0 captures the selection; stage i captures stage i-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i < STAGES; i++) data_p[i] <= '0;
    end else if (flush) begin
      vld_p <= '0;
      for (int i = 0; i < STAGES; i++) data_p[i] <= '0;
    end else if (!stall) begin
      vld_p[0]  <= cap_vld;
      data_p[0] <= cap_data;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i]  <= vld_p[i-1];
        data_p[i] <= data_p[i-1];
      end
    end
  end

  assign out_data  = data_p[STAGES-1];
  assign out_valid = vld_p[STAGES-1];
  assign busy      = |vld_p;

endmodule

// File: tb/tb_pipe_select_mux.sv
// Scoreboard bench for pipe_select_mux: driver pushes expected slots, a monitor pops on out_valid.
module tb_pipe_select_mux;
  localparam int WIDTH  = 5;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 3;
  localparam int STAGES = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid, stall, flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid, sel_err, busy;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } exp_t;
  exp_t sb[$];

  pipe_select_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .sel_err(sel_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] d, input logic e);
    sel      = s;
    in_valid = 1'b1;
    sb.push_back('{data: d, err: e});
  endtask

  // Monitor: every valid output must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(out_data), 32'hDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_data", 32'(out_data), 32'(e.data));
          check("sb_err", 32'(sel_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] held;
    rst = 1'b1; sel = '0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    in_bus = {5'b11111, 5'b00000, 5'b10101, 5'b01010};

    // Reset state
    step(); step();
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sel_err", 32'(sel_err), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;

    // Single slot latency
    issue(3'd1, 5'b10101, 1'b0);
    step(); in_valid = 1'b0;
    check("lat_e1_busy", 32'(busy), 1);
    check("lat_e1_valid", 32'(out_valid), 0);
    step();
    check("lat_e2_valid", 32'(out_valid), 0);
    step();
    check("lat_e3_valid", 32'(out_valid), 1);
    check("lat_e3_data", 32'(out_data), 32'b10101);
    step();
    check("lat_e4_busy", 32'(busy), 0);
    check("lat_e4_valid", 32'(out_valid), 0);

    // Streaming, one slot per cycle
    issue(3'd0, 5'b01010, 1'b0); step();
    issue(3'd1, 5'b10101, 1'b0); step();
    issue(3'd2, 5'b00000, 1'b0); step();
    issue(3'd3, 5'b11111, 1'b0); step();
    in_valid = 1'b0;
    check("stream_e4_valid", 32'(out_valid), 1);
    step(); check("stream_e5_valid", 32'(out_valid), 1);
    step(); check("stream_e6_valid", 32'(out_valid), 1);
    step(); check("stream_drained", 32'(busy), 0);

    // Stall for two cycles
    issue(3'd3, 5'b11111, 1'b0); step();
    in_valid = 1'b0; stall = 1'b1;
    step(); held = out_data;
    check("stall_e2_valid", 32'(out_valid), 0);
    step();
    check("stall_e3_valid", 32'(out_valid), 0);
    check("stall_e3_hold", 32'(out_data), 32'(held));
    check("stall_e3_busy", 32'(busy), 1);
    stall = 1'b0;
    step(); check("stall_e4_valid", 32'(out_valid), 0);
    step();
    check("stall_e5_valid", 32'(out_valid), 1);
    check("stall_e5_data", 32'(out_data), 32'b11111);
    step();

    // Flush beats stall; flushed slots never surface
    sel = 3'd1; in_valid = 1'b1; step();
    sel = 3'd2; step();
    sel = 3'd3; flush = 1'b1; stall = 1'b1; step();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 0);
    check("flush_data", 32'(out_data), 0);
    check("flush_busy", 32'(busy), 0);
    repeat (4) step();

    // Out-of-range select
`ifdef PIPE_MUX_RANGE_CHECK_EN
    issue(3'b101, 5'b00000, 1'b1); step();
    issue(3'b111, 5'b00000, 1'b1); step();
`else
    issue(3'b101, 5'b01010, 1'b0); step();
    issue(3'b111, 5'b01010, 1'b0); step();
`endif
    issue(3'd3, 5'b11111, 1'b0); step();
    in_valid = 1'b0;
    repeat (3) step();

    // Asynchronous reset mid-stream
    issue(3'd0, 5'b01010, 1'b0); step();
    issue(3'd1, 5'b10101, 1'b0); step();
    issue(3'd2, 5'b00000, 1'b0); step();
    #1 rst = 1'b1; in_valid = 1'b0;
    #1;
    check("arst_out_data", 32'(out_data), 0);
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_busy", 32'(busy), 0);
    sb.delete();
    step(); rst = 1'b0;
    issue(3'd3, 5'b11111, 1'b0); step(); in_valid = 1'b0;
    step();
    check("arst_resume_e2", 32'(out_valid), 0);
    step();
    check("arst_resume_valid", 32'(out_valid), 1);
    check("arst_resume_data", 32'(out_data), 32'b11111);
    repeat (3) step();

    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
